// File: rtl/otp_seq_ctrl.sv
// otp_seq_ctrl: req/ack sequencer that drives the OTP byte macro pins through timed phases.
// Optional program-verify read pass is enabled by defining OTP_SEQ_VERIFY_EN.

module otp_seq_ctrl #(
   parameter int unsigned T_SETUP = 4,
   parameter int unsigned T_START = 320,
   parameter int unsigned T_PROG  = 15000,
   parameter int unsigned T_READ  = 120,
   parameter int unsigned T_HOLD  = 60,
   parameter int unsigned T_GAP   = 60
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req,
   input  logic       we,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       ack,
   output logic       busy,
   output logic [7:0] rdata,
   output logic       err,
   output logic       VPP,
   output logic       CS,
   output logic       PROG,
   output logic       READ,
   output logic [6:0] ADR,
   output logic [7:0] DIN,
   input  logic [7:0] DO
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_START,
      S_PULSE,
      S_HOLD,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [15:0] L_SETUP = 16'(T_SETUP - 1);
   localparam logic [15:0] L_START = 16'(T_START - 1);
   localparam logic [15:0] L_PROG  = 16'(T_PROG - 1);
   localparam logic [15:0] L_READ  = 16'(T_READ - 1);
   localparam logic [15:0] L_HOLD  = 16'(T_HOLD - 1);
   localparam logic [15:0] L_GAP   = 16'(T_GAP - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_opWe;
   logic        r_verify;
`ifdef OTP_SEQ_VERIFY_EN
   logic        r_mismatch;
`endif

   state_t      w_state;
   logic [15:0] w_cnt;
   logic        w_verify;
   logic        w_phaseEnd;
   logic        w_isProg;
   logic        w_accept;
   logic        w_capture;
   logic        w_busy;
   logic        w_vpp;
   logic        w_cs;
   logic        w_prog;
   logic        w_read;
   logic        w_ack;

   // The verify pass reuses the read path, so a pulse is a program pulse only on the first pass.
   assign w_phaseEnd = (r_cnt == 16'd0);
   assign w_isProg   = r_opWe & ~r_verify;
   assign w_accept   = (r_state == S_IDLE) && req;
   assign w_capture  = (r_state == S_PULSE) && w_phaseEnd && !w_isProg;

   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_verify = r_verify;
      if (!w_phaseEnd) begin
         w_cnt = r_cnt - 16'd1;
      end
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_state  = S_SETUP;
               w_cnt    = L_SETUP;
               w_verify = 1'b0;
            end
         end
         S_SETUP: begin
            if (w_phaseEnd) begin
               w_state = S_START;
               w_cnt   = L_START;
            end
         end
         S_START: begin
            if (w_phaseEnd) begin
               w_state = S_PULSE;
               w_cnt   = w_isProg ? L_PROG : L_READ;
            end
         end
         S_PULSE: begin
            if (w_phaseEnd) begin
               w_state = S_HOLD;
               w_cnt   = L_HOLD;
            end
         end
         S_HOLD: begin
            if (w_phaseEnd) begin
               w_state = S_GAP;
               w_cnt   = L_GAP;
            end
         end
         S_GAP: begin
            if (w_phaseEnd) begin
               w_state = S_DONE;
               w_cnt   = 16'd0;
`ifdef OTP_SEQ_VERIFY_EN
               if (w_isProg) begin
                  w_state  = S_SETUP;
                  w_cnt    = L_SETUP;
                  w_verify = 1'b1;
               end
`endif
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_cnt   = 16'd0;
         end
         default: begin
            w_state = S_IDLE;
            w_cnt   = 16'd0;
         end
      endcase

      // Pin values are decoded from the next state so every output leaves a flop.
      w_busy = (w_state != S_IDLE);
      w_vpp  = w_state inside {S_SETUP, S_START, S_PULSE, S_HOLD};
      w_cs   = w_state inside {S_START, S_PULSE, S_HOLD};
      w_prog = (w_state == S_PULSE) && w_isProg;
      w_read = (w_state == S_PULSE) && !w_isProg;
      w_ack  = (w_state == S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_cnt      <= 16'd0;
         r_opWe     <= 1'b0;
         r_verify   <= 1'b0;
         ack        <= 1'b0;
         busy       <= 1'b0;
         rdata      <= 8'd0;
         err        <= 1'b0;
         VPP        <= 1'b0;
         CS         <= 1'b0;
         PROG       <= 1'b0;
         READ       <= 1'b0;
         ADR        <= 7'd0;
         DIN        <= 8'd0;
`ifdef OTP_SEQ_VERIFY_EN
         r_mismatch <= 1'b0;
`endif
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_verify <= w_verify;
         ack      <= w_ack;
         busy     <= w_busy;
         VPP      <= w_vpp;
         CS       <= w_cs;
         PROG     <= w_prog;
         READ     <= w_read;
         if (w_accept) begin
            r_opWe <= we;
            ADR    <= addr;
            DIN    <= wdata;
         end
         if (w_capture) begin
            rdata <= DO;
         end
`ifdef OTP_SEQ_VERIFY_EN
         if (w_accept) begin
            err <= 1'b0;
         end
         if (w_capture) begin
            r_mismatch <= (DO != DIN);
         end
         if ((r_state == S_GAP) && (w_state == S_DONE) && r_verify && r_mismatch) begin
            err <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_otp_seq_ctrl.sv
// tb_otp_seq_ctrl: randomized, model-checked bench for otp_seq_ctrl with a behavioural OTP macro.
// A second instance with every phase length set to 1 exercises the minimum-parameter case.

module tb_otp_seq_ctrl;

   localparam int TS  = 4;
   localparam int TST = 320;
   localparam int TP  = 15000;
   localparam int TR  = 120;
   localparam int TH  = 60;
   localparam int TG  = 60;
`ifdef OTP_SEQ_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rstN  = 1'b0;
   logic       req   = 1'b0;
   logic       we    = 1'b0;
   logic [6:0] addr  = 7'd0;
   logic [7:0] wdata = 8'd0;
   logic       ack, busy, err, vpp, cs, prog, rd;
   logic [7:0] rdata, dinO, doI;
   logic [6:0] adrO;

   logic       req2   = 1'b0;
   logic       we2    = 1'b0;
   logic [6:0] addr2  = 7'd0;
   logic [7:0] wdata2 = 8'd0;
   logic [7:0] do2    = 8'd0;
   logic       ack2, busy2, err2, vpp2, cs2, prog2, rd2;
   logic [7:0] rdata2, din2;
   logic [6:0] adr2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int reqEdge = 0;
   int monEpoch = 0;
   bit forceDo = 1'b0;
   logic [7:0] forceVal = 8'd0;
   logic [7:0] expMem [128];
   logic [7:0] expRdata = 8'd0;

   otp_seq_ctrl #(.T_SETUP(TS), .T_START(TST), .T_PROG(TP), .T_READ(TR), .T_HOLD(TH), .T_GAP(TG)) dut (
      .CLK(clk), .RST(rstN), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .busy(busy), .rdata(rdata), .err(err),
      .VPP(vpp), .CS(cs), .PROG(prog), .READ(rd), .ADR(adrO), .DIN(dinO), .DO(doI)
   );

   otp_seq_ctrl #(.T_SETUP(1), .T_START(1), .T_PROG(1), .T_READ(1), .T_HOLD(1), .T_GAP(1)) dut2 (
      .CLK(clk), .RST(rstN), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
      .ack(ack2), .busy(busy2), .rdata(rdata2), .err(err2),
      .VPP(vpp2), .CS(cs2), .PROG(prog2), .READ(rd2), .ADR(adr2), .DIN(din2), .DO(do2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Unprogrammed cells read back a fixed address-derived pattern.
   function automatic logic [7:0] baseVal(input logic [6:0] a);
      return {1'b0, a} ^ 8'hB0;
   endfunction

   function automatic int expLat(input bit isProg);
      int lat = 1 + TS + TST + (isProg ? TP : TR) + TH + TG;
      if (isProg && VERIFY) lat += TS + TST + TR + TH + TG;
      return lat;
   endfunction

   // Expected {busy, VPP, CS, READ, PROG, ack} at offset t after acceptance, from the phase list.
   function automatic logic [5:0] expPins(input int t, input int ts, input int tst, input int tp,
                                          input int th, input int tg, input bit isProg);
      int r = t;
      if (r < ts) return 6'b110000;
      r -= ts;
      if (r < tst) return 6'b111000;
      r -= tst;
      if (r < tp) return isProg ? 6'b111010 : 6'b111100;
      r -= tp;
      if (r < th) return 6'b111000;
      r -= th;
      if (r < tg) return 6'b100000;
      r -= tg;
      if (r == 0) return 6'b100001;
      return 6'b000000;
   endfunction

   bit         written [128];
   logic [7:0] memv [128];
   assign doI = forceDo ? forceVal : (written[adrO] ? memv[adrO] : baseVal(adrO));

   int csHigh, rdHigh, prHigh, vppHigh, ackCount, ackCyc, csFirst, pulseFirst, csFall;
   int csRun = 0, progRun = 0, rdRun = 0, seenEpoch = 0;
   bit adrChg, dinChg, wrong;
   bit prevCs = 1'b0, prevProg = 1'b0, prevRd = 1'b0;
   logic [6:0] prevAdr = 7'd0, adrAtProg;
   logic [7:0] prevDin = 8'd0, dinAtProg;

   // Macro model and pin monitor; a cell is written only by a full-length program pulse.
   always @(posedge clk) begin
      #2;
      if (seenEpoch != monEpoch) begin
         seenEpoch = monEpoch;
         csHigh = 0; rdHigh = 0; prHigh = 0; vppHigh = 0; ackCount = 0; ackCyc = -1;
         csFirst = -1; pulseFirst = -1; csFall = -1;
         adrChg = 1'b0; dinChg = 1'b0; wrong = 1'b0; adrAtProg = 7'd0; dinAtProg = 8'd0;
      end
      if (cs) csHigh++;
      if (rd) rdHigh++;
      if (prog) prHigh++;
      if (vpp) vppHigh++;
      if (ack) begin ackCount++; ackCyc = cyc; end
      if (cs && !prevCs && csFirst < 0) csFirst = cyc;
      if (!cs && prevCs) csFall = cyc;
      if ((prog || rd) && !(prevProg || prevRd)) begin
         if (pulseFirst < 0) pulseFirst = cyc;
         if (csRun < 300) wrong = 1'b1;
      end
      if (prog && !prevProg) begin adrAtProg = adrO; dinAtProg = dinO; end
      if (cs && adrO != prevAdr) adrChg = 1'b1;
      if (cs && dinO != prevDin) dinChg = 1'b1;
      if (!prog && prevProg) begin
         if (progRun < 10000 || progRun > 20000) wrong = 1'b1;
         else begin written[prevAdr] = 1'b1; memv[prevAdr] = prevDin; end
      end
      if (!rd && prevRd && rdRun < 100) wrong = 1'b1;
      csRun   = cs ? csRun + 1 : 0;
      progRun = prog ? progRun + 1 : 0;
      rdRun   = rd ? rdRun + 1 : 0;
      prevCs = cs; prevProg = prog; prevRd = rd; prevAdr = adrO; prevDin = dinO;
   end

   task automatic issueReq(input bit w, input logic [6:0] a, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin @(negedge clk); n++; end
      monEpoch++;
      we = w; addr = a; wdata = d; req = 1'b1;
      reqEdge = cyc + 1;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic waitAck(input int limit, output bit to);
      int n = 0;
      while (ackCount == 0 && n < limit) begin @(negedge clk); n++; end
      to = (ackCount == 0);
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ack, busy, err, vpp, cs, prog, rd, adrO, dinO, rdata} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got %h want 0", {ack, busy, err, vpp, cs, prog, rd, adrO, dinO, rdata});
      end
      checks++;
      if ({ack2, busy2, vpp2, cs2, prog2, rd2, rdata2} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs_short got %h want 0", {ack2, busy2, vpp2, cs2, prog2, rd2, rdata2});
      end
      rstN = 1'b1;
      expRdata = 8'd0;
   endtask

   task automatic test_read();
      bit to;
      int lat;
      issueReq(1'b0, 7'h15, 8'h00);
      waitAck(expLat(1'b0) + 100, to);
      lat = ackCyc + 1 - reqEdge;
      checks++;
      if (to) begin errors++; $display("[TB] FAIL read_ack_timeout got none want ack"); end
      checks++;
      if (lat != expLat(1'b0)) begin errors++; $display("[TB] FAIL read_latency got %0d want %0d", lat, expLat(1'b0)); end
      checks++;
      if (csHigh != TST + TR + TH) begin errors++; $display("[TB] FAIL read_cs_cycles got %0d want %0d", csHigh, TST + TR + TH); end
      checks++;
      if (rdHigh != TR) begin errors++; $display("[TB] FAIL read_pulse_cycles got %0d want %0d", rdHigh, TR); end
      checks++;
      if (prHigh != 0) begin errors++; $display("[TB] FAIL read_prog_cycles got %0d want 0", prHigh); end
      checks++;
      if (csFirst - reqEdge != TS) begin errors++; $display("[TB] FAIL read_cs_rise got %0d want %0d", csFirst - reqEdge, TS); end
      checks++;
      if (pulseFirst - reqEdge != TS + TST) begin errors++; $display("[TB] FAIL read_pulse_rise got %0d want %0d", pulseFirst - reqEdge, TS + TST); end
      expRdata = expMem[7'h15];
      checks++;
      if (rdata !== expRdata) begin errors++; $display("[TB] FAIL read_rdata got %h want %h", rdata, expRdata); end
      @(negedge clk);
      checks++;
      if ({busy, ack} !== 2'b00) begin errors++; $display("[TB] FAIL read_busy_fall got %b want 00", {busy, ack}); end
   endtask

   task automatic test_program();
      bit to;
      int lat;
      int expVpp;
      issueReq(1'b1, 7'h7F, 8'h3C);
      waitAck(expLat(1'b1) + 100, to);
      lat = ackCyc + 1 - reqEdge;
      expVpp = (TS + TST + TP + TH) + (VERIFY ? TS + TST + TR + TH : 0);
      checks++;
      if (to) begin errors++; $display("[TB] FAIL prog_ack_timeout got none want ack"); end
      checks++;
      if (lat != expLat(1'b1)) begin errors++; $display("[TB] FAIL prog_latency got %0d want %0d", lat, expLat(1'b1)); end
      checks++;
      if (prHigh != TP) begin errors++; $display("[TB] FAIL prog_pulse_cycles got %0d want %0d", prHigh, TP); end
      checks++;
      if (vppHigh != expVpp) begin errors++; $display("[TB] FAIL prog_vpp_cycles got %0d want %0d", vppHigh, expVpp); end
      checks++;
      if (rdHigh != (VERIFY ? TR : 0)) begin errors++; $display("[TB] FAIL prog_read_cycles got %0d want %0d", rdHigh, VERIFY ? TR : 0); end
      checks++;
      if ({adrAtProg, dinAtProg} !== {7'h7F, 8'h3C}) begin errors++; $display("[TB] FAIL prog_pins got %h/%h want 7f/3c", adrAtProg, dinAtProg); end
      checks++;
      if ({adrChg, dinChg, wrong, err} !== 4'b0000) begin errors++; $display("[TB] FAIL prog_stable got %b want 0000", {adrChg, dinChg, wrong, err}); end
      if (VERIFY) expRdata = 8'h3C;
      checks++;
      if (rdata !== expRdata) begin errors++; $display("[TB] FAIL prog_rdata got %h want %h", rdata, expRdata); end
      expMem[7'h7F] = 8'h3C;
      issueReq(1'b0, 7'h7F, 8'h00);
      waitAck(expLat(1'b0) + 100, to);
      expRdata = expMem[7'h7F];
      checks++;
      if (to || rdata !== expRdata) begin errors++; $display("[TB] FAIL prog_readback got %h want %h", rdata, expRdata); end
   endtask

   task automatic test_back_to_back();
      bit to;
      int fall1, ack1, gap;
      issueReq(1'b0, 7'h01, 8'h00);
      repeat (150) @(negedge clk);
      we = 1'b1; addr = 7'h33; wdata = 8'h99; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      waitAck(expLat(1'b0) + 100, to);
      expRdata = expMem[7'h01];
      checks++;
      if (to || rdata !== expRdata) begin errors++; $display("[TB] FAIL b2b_first_rdata got %h want %h", rdata, expRdata); end
      checks++;
      if ({prHigh != 0, adrChg, ackCount != 1} !== 3'b000) begin
         errors++; $display("[TB] FAIL b2b_ignored_req got prog=%0d adrchg=%b acks=%0d want 0/0/1", prHigh, adrChg, ackCount);
      end
      fall1 = csFall;
      ack1 = ackCyc;
      issueReq(1'b0, 7'h02, 8'h00);
      checks++;
      if (reqEdge - ack1 != 2) begin errors++; $display("[TB] FAIL b2b_accept got %0d want 2", reqEdge - ack1); end
      waitAck(expLat(1'b0) + 100, to);
      gap = csFirst - fall1;
      checks++;
      if (gap < TG + TS + 2) begin errors++; $display("[TB] FAIL b2b_cs_gap got %0d want >= %0d", gap, TG + TS + 2); end
      expRdata = expMem[7'h02];
      checks++;
      if (to || rdata !== expRdata || adrChg) begin errors++; $display("[TB] FAIL b2b_second got %h adrchg=%b want %h", rdata, adrChg, expRdata); end
      repeat (50) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ackCount != 1) begin errors++; $display("[TB] FAIL b2b_not_queued got busy=%b acks=%0d want 0/1", busy, ackCount); end
   endtask

   task automatic test_reset_mid_pulse();
      bit to;
      int n = 0;
      issueReq(1'b1, 7'h40, 8'h0F);
      while (!prog && n < TS + TST + 50) begin @(negedge clk); n++; end
      checks++;
      if (prog !== 1'b1) begin errors++; $display("[TB] FAIL rst_prog_start got %b want 1", prog); end
      repeat (200) @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      checks++;
      if ({prog, cs, vpp, busy, ack} !== 5'b00000) begin errors++; $display("[TB] FAIL rst_abort_pins got %b want 00000", {prog, cs, vpp, busy, ack}); end
      rstN = 1'b1;
      expRdata = 8'd0;
      repeat (200) @(negedge clk);
      checks++;
      if (ackCount != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_ack got acks=%0d busy=%b want 0/0", ackCount, busy); end
      issueReq(1'b0, 7'h40, 8'h00);
      waitAck(expLat(1'b0) + 100, to);
      expRdata = expMem[7'h40];
      checks++;
      if (to || rdata !== expRdata || ackCyc + 1 - reqEdge != expLat(1'b0)) begin
         errors++; $display("[TB] FAIL rst_followup_read got %h lat %0d want %h lat %0d", rdata, ackCyc + 1 - reqEdge, expRdata, expLat(1'b0));
      end
   endtask

   task automatic test_verify();
      bit to;
      forceDo = 1'b1;
      forceVal = 8'h54;
      issueReq(1'b1, 7'h2A, 8'h55);
      waitAck(expLat(1'b1) + 100, to);
      forceDo = 1'b0;
      if (VERIFY) expRdata = 8'h54;
      checks++;
      if (to || ackCyc + 1 - reqEdge != expLat(1'b1)) begin errors++; $display("[TB] FAIL verify_latency got %0d want %0d", ackCyc + 1 - reqEdge, expLat(1'b1)); end
      checks++;
      if (rdHigh != (VERIFY ? TR : 0)) begin errors++; $display("[TB] FAIL verify_read_pulse got %0d want %0d", rdHigh, VERIFY ? TR : 0); end
      checks++;
      if (err !== VERIFY) begin errors++; $display("[TB] FAIL verify_err got %b want %b", err, VERIFY); end
      checks++;
      if (rdata !== expRdata) begin errors++; $display("[TB] FAIL verify_rdata got %h want %h", rdata, expRdata); end
      expMem[7'h2A] = 8'h55;
      issueReq(1'b0, 7'h2A, 8'h00);
      checks++;
      if (err !== 1'b0) begin errors++; $display("[TB] FAIL verify_err_clear got %b want 0", err); end
      waitAck(expLat(1'b0) + 100, to);
      expRdata = expMem[7'h2A];
      checks++;
      if (to || rdata !== expRdata) begin errors++; $display("[TB] FAIL verify_readback got %h want %h", rdata, expRdata); end
   endtask

   task automatic test_random();
      bit to, w, progUsed;
      logic [6:0] a;
      logic [7:0] d;
      progUsed = 1'b0;
      for (int i = 0; i < 6; i++) begin
         w = !progUsed && ($urandom_range(0, 2) == 0);
         if (w) progUsed = 1'b1;
         a = 7'($urandom_range(0, 127));
         d = 8'($urandom);
         issueReq(w, a, d);
         waitAck(expLat(w) + 100, to);
         if (w) begin
            expMem[a] = d;
            if (VERIFY) expRdata = d;
         end else begin
            expRdata = expMem[a];
         end
         checks++;
         if (to || ackCyc + 1 - reqEdge != expLat(w)) begin errors++; $display("[TB] FAIL rand_latency op %0d got %0d want %0d", i, ackCyc + 1 - reqEdge, expLat(w)); end
         checks++;
         if (rdata !== expRdata || err !== 1'b0 || wrong) begin
            errors++; $display("[TB] FAIL rand_result op %0d got %h err=%b wrong=%b want %h/0/0", i, rdata, err, wrong, expRdata);
         end
      end
   endtask

   task automatic test_short_params();
      logic [5:0] got, want;
      logic [7:0] dv;
      logic [6:0] av;
      dv = 8'($urandom);
      av = 7'($urandom_range(0, 127));
      @(negedge clk);
      do2 = dv; addr2 = av; req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      for (int t = 0; t < 7; t++) begin
         got = {busy2, vpp2, cs2, rd2, prog2, ack2};
         want = expPins(t, 1, 1, 1, 1, 1, 1'b0);
         checks++;
         if (got !== want) begin errors++; $display("[TB] FAIL short_phase t=%0d got %b want %b", t, got, want); end
         @(negedge clk);
      end
      checks++;
      if ({rdata2, adr2} !== {dv, av}) begin errors++; $display("[TB] FAIL short_rdata got %h/%h want %h/%h", rdata2, adr2, dv, av); end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) expMem[i] = baseVal(7'(i));
      test_reset();
      test_read();
      test_program();
      test_back_to_back();
      test_reset_mid_pulse();
      test_verify();
      test_random();
      test_short_params();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
